// File: rtl/led_stream_decoder_if.sv
// Bus bundle for the WS2812B receive decoder: serial line in, pixel/frame status out.
// master is the decoder side, slave is the consumer/driver side.
interface led_stream_decoder_if;
  logic        dataIn;
  logic [23:0] pixel;
  logic        pixelValid;
  logic [7:0]  pixelIndex;
  logic        frameDone;
  logic [7:0]  frameCount;
  logic        errFlag;
  logic        overflow;

  modport master (
    input  dataIn,
    output pixel, pixelValid, pixelIndex, frameDone, frameCount, errFlag, overflow
  );

  modport slave (
    output dataIn,
    input  pixel, pixelValid, pixelIndex, frameDone, frameCount, errFlag, overflow
  );
endinterface

// File: rtl/led_stream_decoder.sv
// WS2812B NRZ receiver: pulse-width bit classification, 24-bit GRB pixel assembly, frame-end detect.
// pixelValid on the 3rd clk edge after the 24th bit's falling edge; no backpressure, strobes are 1 cycle.
module led_stream_decoder #(
  parameter int unsigned T_THRESH   = 60,
  parameter int unsigned T_MIN_HIGH = 15,
  parameter int unsigned T_MAX_HIGH = 110,
  parameter int unsigned T_RESET    = 5000,
  parameter int unsigned MAX_PIXELS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  led_stream_decoder_if.master bus
);

  localparam logic [15:0] THRESH_C   = 16'(T_THRESH);
  localparam logic [15:0] MIN_HIGH_C = 16'(T_MIN_HIGH);
  localparam logic [15:0] MAX_HIGH_C = 16'(T_MAX_HIGH);
  localparam logic [15:0] RESET_C    = 16'(T_RESET);
  localparam logic [7:0]  MAX_PIX_C  = 8'(MAX_PIXELS);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t      state_q;
  logic        s1_q, s2_q, s3_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [22:0] shift_q;
  logic [23:0] shift_d;
  logic [4:0]  bit_cnt_q;
  logic [7:0]  pix_cnt_q;
  logic [7:0]  pix_cnt_d;
  logic [23:0] pixel_q;
  logic        pixel_vld_q;
  logic [7:0]  pixel_idx_q;
  logic        frame_done_q;
  logic [7:0]  frame_cnt_q;
  logic        err_q;
  logic        ovf_q;

  logic rise, fall, bit_ok;

  assign rise      = s2_q & ~s3_q;
  assign fall      = ~s2_q & s3_q;
  assign cnt_d     = (rise || fall) ? 16'd0 : ((cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1);
  assign bit_ok    = (cnt_q >= MIN_HIGH_C) && (cnt_q <= MAX_HIGH_C);
  // The 24th bit completes the word directly from shift_d, so only 23 bits need storing.
  assign shift_d   = {shift_q, (cnt_q >= THRESH_C)};
  assign pix_cnt_d = (pix_cnt_q == 8'hFF) ? pix_cnt_q : pix_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SYNC;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      cnt_q        <= 16'd0;
      shift_q      <= 23'd0;
      bit_cnt_q    <= 5'd0;
      pix_cnt_q    <= 8'd0;
      pixel_q      <= 24'd0;
      pixel_vld_q  <= 1'b0;
      pixel_idx_q  <= 8'd0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      s1_q         <= bus.dataIn;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      cnt_q        <= cnt_d;
      pixel_vld_q  <= 1'b0;
      frame_done_q <= 1'b0;

      case (state_q)
        // Any rise clears cnt_q, so only an unbroken low run of T_RESET cycles aligns us.
        SYNC: begin
          if (!s2_q && (cnt_q >= RESET_C)) state_q <= IDLE;
        end

        IDLE: begin
          if (rise) begin
            state_q   <= HIGH;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            bit_cnt_q <= 5'd0;
            pix_cnt_q <= 8'd0;
          end
        end

        HIGH: begin
          if (fall) begin
            state_q <= LOW;
            if (!bit_ok) begin
              err_q <= 1'b1;
            end else begin
              shift_q <= shift_d[22:0];
              if (bit_cnt_q == 5'd23) begin
                pixel_q     <= shift_d;
                pixel_vld_q <= 1'b1;
                pixel_idx_q <= pix_cnt_q;
                pix_cnt_q   <= pix_cnt_d;
                bit_cnt_q   <= 5'd0;
                if (pix_cnt_q >= MAX_PIX_C) begin
                  ovf_q <= 1'b1;
                  err_q <= 1'b1;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end else if (cnt_q > MAX_HIGH_C) begin
            err_q <= 1'b1;
          end
        end

        LOW: begin
          if (rise) begin
            state_q <= HIGH;
          end else if (cnt_q >= RESET_C) begin
            state_q   <= IDLE;
            bit_cnt_q <= 5'd0;
            if ((bit_cnt_q != 5'd0) || (pix_cnt_q != 8'd0)) begin
              frame_done_q <= 1'b1;
              frame_cnt_q  <= pix_cnt_q;
              if (bit_cnt_q != 5'd0) err_q <= 1'b1;
            end
          end
        end

        default: state_q <= SYNC;
      endcase
    end
  end

  assign bus.pixel      = pixel_q;
  assign bus.pixelValid = pixel_vld_q;
  assign bus.pixelIndex = pixel_idx_q;
  assign bus.frameDone  = frame_done_q;
  assign bus.frameCount = frame_cnt_q;
  assign bus.errFlag    = err_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_led_stream_decoder.sv
// Scoreboard bench for led_stream_decoder: stimulus pushes expected pixels/frames, a monitor pops on strobes.
module tb_led_stream_decoder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  led_stream_decoder_if bus();

  led_stream_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [23:0] pix;
    logic [7:0]  idx;
    logic        ovf;
  } pix_exp_t;

  typedef struct {
    logic [7:0] cnt;
    logic       err;
    logic       ovf;
  } frm_exp_t;

  pix_exp_t pq[$];
  frm_exp_t fq[$];
  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.dataIn = 1'b0;
    cycles(n);
  endtask

  task automatic send_bit(input logic b);
    int h;
    h = b ? 80 : 40;
    bus.dataIn = 1'b1;
    cycles(h);
    bus.dataIn = 1'b0;
    cycles(125 - h);
  endtask

  task automatic send_pixel(input logic [23:0] v);
    for (int i = 23; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic exp_pixel(input logic [23:0] v, input logic [7:0] idx, input logic ovf);
    pix_exp_t e;
    e.pix = v; e.idx = idx; e.ovf = ovf;
    pq.push_back(e);
  endtask

  task automatic exp_frame(input logic [7:0] cnt, input logic err, input logic ovf);
    frm_exp_t e;
    e.cnt = cnt; e.err = err; e.ovf = ovf;
    fq.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pixel"},      32'(bus.pixel),      32'd0);
    check({tag, "_pixelValid"}, 32'(bus.pixelValid), 32'd0);
    check({tag, "_pixelIndex"}, 32'(bus.pixelIndex), 32'd0);
    check({tag, "_frameDone"},  32'(bus.frameDone),  32'd0);
    check({tag, "_frameCount"}, 32'(bus.frameCount), 32'd0);
    check({tag, "_errFlag"},    32'(bus.errFlag),    32'd0);
    check({tag, "_overflow"},   32'(bus.overflow),   32'd0);
  endtask

  // Monitor: compare every strobe against the head of its queue.
  always @(negedge clk) begin
    pix_exp_t pe;
    frm_exp_t fe;
    if (!reset && bus.pixelValid) begin
      if (pq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pixel: pixel 0x%06h index %0d, none expected", bus.pixel, bus.pixelIndex);
      end else begin
        pe = pq.pop_front();
        check("pixel_value", 32'(bus.pixel),      32'(pe.pix));
        check("pixel_index", 32'(bus.pixelIndex), 32'(pe.idx));
        check("pixel_ovf",   32'(bus.overflow),   32'(pe.ovf));
      end
    end
    if (!reset && bus.frameDone) begin
      if (fq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_frame: frameCount %0d, none expected", bus.frameCount);
      end else begin
        fe = fq.pop_front();
        check("frame_count", 32'(bus.frameCount), 32'(fe.cnt));
        check("frame_err",   32'(bus.errFlag),    32'(fe.err));
        check("frame_ovf",   32'(bus.overflow),   32'(fe.ovf));
      end
    end
  end

  initial begin
    #990000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passed, checks);
    $fatal(1);
  end

  initial begin
    logic [23:0] p4;
    logic [23:0] p5;
    logic [23:0] p6;
    logic [23:0] p7;

    reset      = 1'b1;
    bus.dataIn = 1'b0;
    cycles(3);
    check_reset_outputs("rst");
    reset = 1'b0;

    // 1: single pixel frame after the initial resync period
    idle(6000);
    exp_pixel(24'hFF0000, 8'd0, 1'b0);
    exp_frame(8'd1, 1'b0, 1'b0);
    send_pixel(24'hFF0000);
    idle(5000);

    // 2: four pixels, exactly at the limit
    exp_pixel(24'h00FF00, 8'd0, 1'b0);
    exp_pixel(24'h0000FF, 8'd1, 1'b0);
    exp_pixel(24'hA5A5A5, 8'd2, 1'b0);
    exp_pixel(24'h123456, 8'd3, 1'b0);
    exp_frame(8'd4, 1'b0, 1'b0);
    send_pixel(24'h00FF00);
    send_pixel(24'h0000FF);
    send_pixel(24'hA5A5A5);
    send_pixel(24'h123456);
    idle(5000);

    // 3: five pixels, the fifth overflows but is still reported
    exp_pixel(24'h010203, 8'd0, 1'b0);
    exp_pixel(24'h405060, 8'd1, 1'b0);
    exp_pixel(24'h8899AA, 8'd2, 1'b0);
    exp_pixel(24'hF0E1D2, 8'd3, 1'b0);
    exp_pixel(24'h7E7E7E, 8'd4, 1'b1);
    exp_frame(8'd5, 1'b1, 1'b1);
    send_pixel(24'h010203);
    send_pixel(24'h405060);
    send_pixel(24'h8899AA);
    send_pixel(24'hF0E1D2);
    send_pixel(24'h7E7E7E);
    idle(5000);

    // 4: 10-cycle glitch after 10 good bits is dropped, pixel keeps the 24 good bits
    p4 = 24'h3C5AF0;
    exp_pixel(p4, 8'd0, 1'b0);
    exp_frame(8'd1, 1'b1, 1'b0);
    for (int i = 23; i >= 14; i--) send_bit(p4[i]);
    bus.dataIn = 1'b1;
    cycles(10);
    bus.dataIn = 1'b0;
    cycles(115);
    for (int i = 13; i >= 0; i--) send_bit(p4[i]);
    idle(5000);

    // 5: 30 bits -> one pixel plus a discarded partial
    p5 = 24'h5A0F33;
    exp_pixel(p5, 8'd0, 1'b0);
    exp_frame(8'd1, 1'b1, 1'b0);
    send_pixel(p5);
    for (int i = 0; i < 6; i++) send_bit(i[0]);
    idle(5000);

    // 6: reset after 12 bits, stream keeps going; nothing reported until resync
    p6 = 24'h777777;
    for (int i = 23; i >= 12; i--) send_bit(p6[i]);
    reset = 1'b1;
    cycles(1);
    check_reset_outputs("midrst");
    reset = 1'b0;
    for (int i = 11; i >= 8; i--) send_bit(p6[i]);
    idle(5000);
    p7 = 24'hC33C96;
    exp_pixel(p7, 8'd0, 1'b0);
    exp_frame(8'd1, 1'b0, 1'b0);
    send_pixel(p7);
    idle(5000);

    check("pixels_outstanding", 32'(pq.size()), 32'd0);
    check("frames_outstanding", 32'(fq.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
